// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver.
//   HEX_SEG    : hex nibble -> {a,b,c,d,e,f,g}, active low (index = nibble)
//   SEG_OFF    : all seven segments dark
//   CATH_BLANK : cathode bus fully dark (segments and dp)
//   AN_OFF     : anode bus fully dark, sliced down to the digit count in use
package ssd_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [7:0] CATH_BLANK = 8'hFF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Entry 15 first so that HEX_SEG[n] selects nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Bundle between the game logic (master) and the scan driver (slave).
//   digits_in   : hex nibbles, nibble i = digit i, digit 0 rightmost
//   dp_in       : decimal point per digit, 1 = lit
//   digit_en    : live per-digit enable, 0 = dark
//   load        : one-cycle strobe capturing digits_in/dp_in
//   brightness  : PWM duty, 0 = dark
//   lz_suppress : blank leading zeros
//   an_n        : anodes, active low
//   cath_n      : {a,b,c,d,e,f,g,dp}, active low
//   frame_tick  : one-cycle pulse after the scan wraps to digit 0
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DIM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [DIM_BITS-1:0]     brightness;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [7:0]              cath_n;
  logic                    frame_tick;

  modport master (
    output digits_in, dp_in, digit_en, load, brightness, lz_suppress,
    input  an_n, cath_n, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, digit_en, load, brightness, lz_suppress,
    output an_n, cath_n, frame_tick
  );
endinterface

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to seven-segment decoder.
//   i_nib : hex value 0..F
//   o_seg : {a,b,c,d,e,f,g}, active low
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver with shadowed (tear-free) display
// data, per-digit enable, leading-zero blanking and PWM brightness.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ssd_scan_driver_if slave (data/control in, an_n/cath_n/frame_tick out)
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int DIM_BITS      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ssd_scan_driver_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [SCAN_DIV_BITS-1:0] r_presc;
  logic [IDX_W-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0]  r_pend_dig;
  logic [NUM_DIGITS-1:0]    r_pend_dp;
  logic [4*NUM_DIGITS-1:0]  r_act_dig;
  logic [NUM_DIGITS-1:0]    r_act_dp;
  logic [NUM_DIGITS-1:0]    r_an_n;
  logic [7:0]               r_cath_n;
  logic                     r_frame_tick;

  logic                     w_slot_end;
  logic                     w_frame_end;
  logic [NUM_DIGITS-1:0]    w_nib_zero;
  logic [NUM_DIGITS-1:0]    w_tail_zero;
  logic [NUM_DIGITS-1:0]    w_suppress;
  logic [3:0]               w_cur_nib;
  logic [6:0]               w_seg;
  logic [6:0]               w_seg_shown;
  logic                     w_lit;
  logic [NUM_DIGITS-1:0]    w_an_n;

  assign w_slot_end  = &r_presc;
  assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 always shows so that an all-zero value still reads "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign w_nib_zero[gi]  = (r_act_dig[4*gi +: 4] == 4'h0);
    assign w_tail_zero[gi] = &w_nib_zero[NUM_DIGITS-1:gi];
    assign w_suppress[gi]  = bus.lz_suppress && (gi != 0) && w_tail_zero[gi];
  end

  assign w_cur_nib = r_act_dig[{r_idx, 2'b00} +: 4];

  ssd_hex_decoder u_dec (
    .i_nib (w_cur_nib),
    .o_seg (w_seg)
  );

  assign w_seg_shown = w_suppress[r_idx] ? SEG_OFF : w_seg;

  // PWM window from the prescaler top bits; prescaler==0 is masked so the
  // first cycle of every slot is dark and the previous digit cannot ghost.
  assign w_lit = (r_presc != '0)
              && (r_presc[SCAN_DIV_BITS-1 -: DIM_BITS] < bus.brightness)
              && bus.digit_en[r_idx];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign w_an_n[gi] = ~(w_lit && (r_idx == IDX_W'(gi)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend_dig   <= '0;
      r_pend_dp    <= '0;
      r_act_dig    <= '0;
      r_act_dp     <= '0;
      r_an_n       <= AN_OFF[NUM_DIGITS-1:0];
      r_cath_n     <= CATH_BLANK;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= r_presc + SCAN_DIV_BITS'(1);
      r_frame_tick <= w_frame_end;
      if (w_slot_end) begin
        r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
      end
      if (bus.load) begin
        r_pend_dig <= bus.digits_in;
        r_pend_dp  <= bus.dp_in;
      end
      // A load landing on the boundary bypasses pending so it is not lost
      // for a whole frame.
      if (w_frame_end) begin
        r_act_dig <= bus.load ? bus.digits_in : r_pend_dig;
        r_act_dp  <= bus.load ? bus.dp_in     : r_pend_dp;
      end
      r_an_n   <= w_an_n;
      r_cath_n <= {w_seg_shown, ~r_act_dp[r_idx]};
    end
  end

  assign bus.an_n       = r_an_n;
  assign bus.cath_n     = r_cath_n;
  assign bus.frame_tick = r_frame_tick;

endmodule
